// File: rtl/scoreboard_pkg.sv
// Shared definitions for the writeback path: functional-unit indices and
// the default datapath dimensions used by the arbiter, its interface and benches.
package scoreboard_pkg;

  localparam int NUM_FU     = 4;
  localparam int FU_BITS    = 2;
  localparam int REG_BITS   = 5;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [FU_BITS-1:0] {
    FU_INT = 2'd0,
    FU_MUL = 2'd1,
    FU_DIV = 2'd2,
    FU_ADD = 2'd3
  } fu_id_e;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of FU result ports and the register-file write port.
// slave: the arbiter side; master: the FUs / register-file environment side.
interface writeback_arbiter_if #(
  parameter int NUM_FU     = scoreboard_pkg::NUM_FU,
  parameter int FU_BITS    = scoreboard_pkg::FU_BITS,
  parameter int REG_BITS   = scoreboard_pkg::REG_BITS,
  parameter int DATA_WIDTH = scoreboard_pkg::DATA_WIDTH
);

  logic [NUM_FU-1:0]            fu_valid;
  logic [NUM_FU-1:0]            fu_ready;
  logic [NUM_FU*REG_BITS-1:0]   fu_dest;
  logic [NUM_FU*DATA_WIDTH-1:0] fu_data;
  logic [NUM_FU-1:0]            fu_wb_block;

  logic                         rf_write_en;
  logic [REG_BITS-1:0]          rf_write_addr;
  logic [DATA_WIDTH-1:0]        rf_write_data;
  logic                         wb_done;
  logic [FU_BITS-1:0]           wb_fu_id;

  modport slave (
    input  fu_valid, fu_dest, fu_data, fu_wb_block,
    output fu_ready, rf_write_en, rf_write_addr, rf_write_data, wb_done, wb_fu_id
  );

  modport master (
    output fu_valid, fu_dest, fu_data, fu_wb_block,
    input  fu_ready, rf_write_en, rf_write_addr, rf_write_data, wb_done, wb_fu_id
  );

endinterface

// File: rtl/writeback_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping) receives a one-hot grant. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int   idx;
  logic found;

  // Scan from ptr upward, wrapping, and grant the first active request.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Serialises FU results onto the single register-file write port.
// Each FU owns a one-entry slot; eligible (valid, not WAR-blocked) slots are
// granted round-robin and the winner is written out one cycle after its grant.
module writeback_arbiter #(
  parameter int NUM_FU     = scoreboard_pkg::NUM_FU,
  parameter int FU_BITS    = scoreboard_pkg::FU_BITS,
  parameter int REG_BITS   = scoreboard_pkg::REG_BITS,
  parameter int DATA_WIDTH = scoreboard_pkg::DATA_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  writeback_arbiter_if.slave wb
);

  import scoreboard_pkg::*;

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]     slot_valid;
  logic [REG_BITS-1:0]   slot_dest [NUM_FU];
  logic [DATA_WIDTH-1:0] slot_data [NUM_FU];

  logic [NUM_FU-1:0]     eligible;
  logic [NUM_FU-1:0]     grant;
  logic [NUM_FU-1:0]     take;
  logic [FU_BITS-1:0]    rr_ptr;

  logic [FU_BITS-1:0]    grant_idx;
  logic [REG_BITS-1:0]   sel_dest;
  logic [DATA_WIDTH-1:0] sel_data;

  assign eligible    = slot_valid & ~wb.fu_wb_block;
  // A granted slot drains this cycle, so it can be refilled at the same edge.
  assign wb.fu_ready = ~slot_valid | grant;
  // Inputs are only looked at when a transfer happens, so X on idle ports stays out.
  assign take        = wb.fu_valid & wb.fu_ready;

  rr_arbiter #(.N(NUM_FU), .PW(PTR_W)) u_rr (
    .req   (eligible),
    .ptr   (rr_ptr[PTR_W-1:0]),
    .grant (grant)
  );

  // Encode the one-hot grant and select the winning slot's contents.
  always_comb begin
    grant_idx = '0;
    sel_dest  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        grant_idx = FU_BITS'(i);
        sel_dest  = slot_dest[i];
        sel_data  = slot_data[i];
      end
    end
  end

  // Slot occupancy: cleared on grant, set on transfer (refill wins over drain).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
    end else begin
      slot_valid <= (slot_valid & ~grant) | take;
    end
  end

  // Slot payload capture; contents are meaningless while the slot is invalid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (take[i]) begin
        slot_dest[i] <= wb.fu_dest[i*REG_BITS +: REG_BITS];
        slot_data[i] <= wb.fu_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin pointer moves just past the winner; holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      if (int'(grant_idx) == NUM_FU - 1) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= grant_idx + 1'b1;
      end
    end
  end

  // Registered write port: r0 retires (wb_done) without asserting the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.rf_write_en   <= 1'b0;
      wb.rf_write_addr <= '0;
      wb.rf_write_data <= '0;
      wb.wb_done       <= 1'b0;
      wb.wb_fu_id      <= '0;
    end else if (|grant) begin
      wb.rf_write_en   <= (sel_dest != '0);
      wb.rf_write_addr <= sel_dest;
      wb.rf_write_data <= sel_data;
      wb.wb_done       <= 1'b1;
      wb.wb_fu_id      <= grant_idx;
    end else begin
      wb.rf_write_en   <= 1'b0;
      wb.wb_done       <= 1'b0;
    end
  end

endmodule
